if_fetch: RTL and testbench

- Instruction-fetch front end of the pipeline.
- Assembles 32-bit little-endian instructions from the byte-wide memory-controller port and raises if_stall while a word is incomplete.
- Obeys the global stall_state bus and jump redirects, then hands {pc, inst} to the IF/ID register.
- Sits upstream of the stall arbiter, whose stall_state it consumes.

---
 rtl/if_fetch_pkg.sv | 20 ++
 rtl/if_fetch.sv | 135 +++++++++++++
 tb/tb_if_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: bus widths,
// stall bit positions, reset polarity and fetch state encodings.
package if_fetch_pkg;

   localparam int STALL_BUS_W = 6;
   localparam int INST_BUS_W  = 32;
   localparam int ADDR_BUS_W  = 32;

   localparam int PC_HOLD = 0;
   localparam int IF_HOLD = 1;

   localparam logic RST_ENABLE = 1'b0;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles little-endian 32-bit words from a byte-wide
// memory port, honours stall_state and jump redirects, presents {inst_pc, inst}.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH_REQ  | byte request pc+idx on mem_req (held until granted, or until
//            | a dropped response has returned when drop=1)
// FETCH_WAIT | request accepted, waiting for mem_valid of byte idx
// FETCH_HOLD | complete word on inst/inst_pc, waiting for IF/ID to take it
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [ADDR_BUS_W-1:0] RESET_PC = 32'h0,
   parameter int                    STALL_W  = STALL_BUS_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STALL_W-1:0]    stall_state,
   input  logic                  jmp_en,
   input  logic [ADDR_BUS_W-1:0] jmp_target,
   output logic                  mem_req,
   output logic [ADDR_BUS_W-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_valid,
   input  logic [7:0]            mem_rdata,
   output logic                  if_stall,
   output logic                  inst_valid,
   output logic [INST_BUS_W-1:0] inst,
   output logic [ADDR_BUS_W-1:0] inst_pc
);

   fetch_state_t          state;
   logic [ADDR_BUS_W-1:0] pc;
   logic [1:0]            idx;
   logic                  drop;

   logic                  accept;
   logic                  drop_next;
   logic                  hold_release;
   logic                  lane_wr;
   logic [3:0]            lane_we;
   logic [ADDR_BUS_W-1:0] jmp_pc;
   logic [ADDR_BUS_W-1:0] byte_addr;
   logic                  unused_bits;

   assign accept       = (state == FETCH_REQ) & mem_req & mem_gnt;
   assign jmp_pc       = {jmp_target[ADDR_BUS_W-1:2], 2'b00};
   assign byte_addr    = pc + {30'd0, idx};
   assign hold_release = (state == FETCH_HOLD) & ~stall_state[IF_HOLD] & ~stall_state[PC_HOLD];
   assign lane_wr      = (state == FETCH_WAIT) & mem_valid & ~drop & ~jmp_en;
   assign lane_we      = lane_wr ? (4'b0001 << idx) : 4'b0000;
   assign if_stall     = (state != FETCH_HOLD) & ~jmp_en;

   // A response still owed by the memory (accepted now, or outstanding in
   // WAIT and not arriving this cycle) must be swallowed after a redirect.
   assign drop_next = ((drop | (state == FETCH_WAIT)) & ~mem_valid) | accept;

   assign unused_bits = ^{stall_state, jmp_target[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         state      <= FETCH_REQ;
         pc         <= RESET_PC;
         idx        <= 2'd0;
         drop       <= 1'b0;
         inst_valid <= 1'b0;
         inst_pc    <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else if (jmp_en) begin
         state      <= FETCH_REQ;
         pc         <= jmp_pc;
         idx        <= 2'd0;
         drop       <= drop_next;
         inst_valid <= 1'b0;
         mem_req    <= ~drop_next;
         mem_addr   <= jmp_pc;
      end else begin
         case (state)
            FETCH_REQ: begin
               if (drop) begin
                  if (mem_valid) begin
                     drop     <= 1'b0;
                     mem_req  <= 1'b1;
                     mem_addr <= byte_addr;
                  end
               end else if (accept) begin
                  state   <= FETCH_WAIT;
                  mem_req <= 1'b0;
               end else begin
                  mem_req  <= 1'b1;
                  mem_addr <= byte_addr;
               end
            end
            FETCH_WAIT: begin
               if (mem_valid) begin
                  if (idx == 2'd3) begin
                     state      <= FETCH_HOLD;
                     inst_valid <= 1'b1;
                     inst_pc    <= pc;
                  end else begin
                     state    <= FETCH_REQ;
                     idx      <= idx + 2'd1;
                     mem_req  <= 1'b1;
                     mem_addr <= byte_addr + 32'd1;
                  end
               end
            end
            FETCH_HOLD: begin
               if (hold_release) begin
                  state      <= FETCH_REQ;
                  pc         <= pc + 32'd4;
                  idx        <= 2'd0;
                  inst_valid <= 1'b0;
                  mem_req    <= 1'b1;
                  mem_addr   <= pc + 32'd4;
               end
            end
            default: state <= FETCH_REQ;
         endcase
      end
   end

   // Byte lanes of the instruction being assembled, written by idx decode.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         inst <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) inst[8*i +: 8] <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory responder plus a word-stream reference model
// (next delivered pc = jump target, else previous delivered pc + 4).
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic [5:0]  stall_state;
   logic        jmp_en;
   logic [31:0] jmp_target;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_valid;
   logic [7:0]  mem_rdata;
   logic        if_stall;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int          checks = 0;
   int          errors = 0;
   int          gnt_pct = 100;
   logic [31:0] seed;
   logic [7:0]  mem [logic [31:0]];
   logic [31:0] req_log [$];

   if_fetch #(.RESET_PC(32'h0), .STALL_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_state (stall_state),
      .jmp_en      (jmp_en),
      .jmp_target  (jmp_target),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_valid   (mem_valid),
      .mem_rdata   (mem_rdata),
      .if_stall    (if_stall),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] h;
      if (mem.exists(a)) return mem[a];
      h = (a ^ seed) * 32'h9E3779B1;
      return h[31:24];
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: memory answers an accepted request exactly one cycle later.
   task automatic cycle();
      logic        acc;
      logic [31:0] a;
      acc = mem_req & mem_gnt;
      a   = mem_addr;
      if (acc) req_log.push_back(a);
      @(posedge clk);
      #1;
      mem_valid = acc;
      mem_rdata = acc ? mem_byte(a) : 8'($urandom);
      mem_gnt   = ($urandom_range(99) < gnt_pct);
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!inst_valid && n < budget) begin
         cycle();
         n++;
      end
      check("wait_inst_valid", {31'd0, inst_valid}, 32'd1);
   endtask

   initial begin
      int          n;
      int          hits;
      int          delivered;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic        consumed;
      logic        prev_valid;

      rst = 1'b1;
      stall_state = 6'd0;
      jmp_en = 1'b0;
      jmp_target = 32'd0;
      mem_gnt = 1'b0;
      mem_valid = 1'b0;
      mem_rdata = 8'd0;
      seed = $urandom;
      mem[32'h0] = 8'h13;
      mem[32'h1] = 8'h00;
      mem[32'h2] = 8'h50;
      mem[32'h3] = 8'h00;

      // Reset state
      #1 rst = 1'b0;
      #2;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      mem_gnt = 1'b1;

      // First word from RESET_PC, best-case timing
      cycle();
      for (int k = 0; k < 4; k++) begin
         check("first_req", {31'd0, mem_req}, 32'd1);
         check("first_addr", mem_addr, k);
         check("first_if_stall", {31'd0, if_stall}, 32'd1);
         cycle();
         check("first_wait_no_req", {31'd0, mem_req}, 32'd0);
         cycle();
      end
      check("first_valid", {31'd0, inst_valid}, 32'd1);
      check("first_inst", inst, 32'h00500013);
      check("first_inst_pc", inst_pc, 32'd0);
      check("first_hold_if_stall", {31'd0, if_stall}, 32'd0);
      cycle();
      check("next_fetch_req", {31'd0, mem_req}, 32'd1);
      check("next_fetch_addr", mem_addr, 32'd4);
      check("next_fetch_valid_low", {31'd0, inst_valid}, 32'd0);

      // Grant withheld for 5 cycles at idx=2
      repeat (4) cycle();
      mem_gnt = 1'b0;
      gnt_pct = 0;
      for (int k = 0; k < 5; k++) begin
         check("nognt_req", {31'd0, mem_req}, 32'd1);
         check("nognt_addr", mem_addr, 32'd6);
         check("nognt_if_stall", {31'd0, if_stall}, 32'd1);
         cycle();
      end
      mem_gnt = 1'b1;
      gnt_pct = 100;
      wait_valid(50, n);
      check("nognt_finish_cycles", n, 32'd4);
      check("nognt_inst_pc", inst_pc, 32'd4);
      check("nognt_inst", inst, word_at(32'd4));

      // IF hold keeps the word and suppresses requests
      stall_state = 6'b000010;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("ifhold_valid", {31'd0, inst_valid}, 32'd1);
         check("ifhold_inst", inst, word_at(32'd4));
         check("ifhold_inst_pc", inst_pc, 32'd4);
         check("ifhold_no_req", {31'd0, mem_req}, 32'd0);
         check("ifhold_if_stall", {31'd0, if_stall}, 32'd0);
      end
      stall_state = 6'd0;
      cycle();
      check("ifhold_release_addr", mem_addr, 32'd8);
      check("ifhold_release_req", {31'd0, mem_req}, 32'd1);
      check("ifhold_release_valid", {31'd0, inst_valid}, 32'd0);

      // Jump while waiting for byte idx=1
      repeat (3) cycle();
      check("jwait_in_wait", {31'd0, mem_req}, 32'd0);
      jmp_en = 1'b1;
      jmp_target = 32'h1002;
      #1;
      check("jwait_if_stall_low", {31'd0, if_stall}, 32'd0);
      req_log.delete();
      cycle();
      jmp_en = 1'b0;
      check("jwait_req", {31'd0, mem_req}, 32'd1);
      check("jwait_addr", mem_addr, 32'h1000);
      check("jwait_valid_low", {31'd0, inst_valid}, 32'd0);
      gnt_pct = 60;
      wait_valid(100, n);
      check("jwait_inst_pc", inst_pc, 32'h1000);
      check("jwait_inst", inst, word_at(32'h1000));
      check("jwait_req_count", req_log.size(), 32'd4);
      for (int k = 0; k < 4 && k < req_log.size(); k++)
         check("jwait_req_addr", req_log[k], 32'h1000 + k);

      // Jump in the same cycle the held word would be consumed
      tgt = $urandom;
      if ((tgt & ~32'd3) == 32'h1004) tgt = 32'h2000;
      jmp_en = 1'b1;
      jmp_target = tgt;
      req_log.delete();
      cycle();
      jmp_en = 1'b0;
      check("jhold_valid_low", {31'd0, inst_valid}, 32'd0);
      check("jhold_addr", mem_addr, tgt & ~32'd3);
      wait_valid(100, n);
      check("jhold_inst_pc", inst_pc, tgt & ~32'd3);
      check("jhold_inst", inst, word_at(tgt & ~32'd3));
      hits = 0;
      foreach (req_log[k]) if (req_log[k] == 32'h1004) hits++;
      check("jhold_old_pc4_never_requested", hits, 32'd0);
      check("jhold_first_req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, tgt & ~32'd3);

      // Jump in the same cycle a request is accepted: response is dropped
      gnt_pct = 100;
      cycle();
      check("jacc_req_pending", {31'd0, mem_req & mem_gnt}, 32'd1);
      tgt = $urandom;
      jmp_en = 1'b1;
      jmp_target = tgt;
      cycle();
      jmp_en = 1'b0;
      check("jacc_drop_no_req", {31'd0, mem_req}, 32'd0);
      cycle();
      check("jacc_reissue_req", {31'd0, mem_req}, 32'd1);
      check("jacc_reissue_addr", mem_addr, tgt & ~32'd3);
      wait_valid(100, n);
      check("jacc_inst_pc", inst_pc, tgt & ~32'd3);
      check("jacc_inst", inst, word_at(tgt & ~32'd3));

      // PC wrap from the top of the address space
      jmp_en = 1'b1;
      jmp_target = 32'hFFFF_FFFE;
      cycle();
      jmp_en = 1'b0;
      wait_valid(100, n);
      check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      check("wrap_inst", inst, word_at(32'hFFFF_FFFC));
      cycle();
      check("wrap_next_addr", mem_addr, 32'd0);
      check("wrap_next_req", {31'd0, mem_req}, 32'd1);

      // PC hold alone must not let the word go
      wait_valid(100, n);
      check("pchold_inst_pc", inst_pc, 32'd0);
      stall_state = 6'b000001;
      repeat (3) cycle();
      check("pchold_valid", {31'd0, inst_valid}, 32'd1);
      check("pchold_no_req", {31'd0, mem_req}, 32'd0);
      check("pchold_inst_pc_stable", inst_pc, 32'd0);
      stall_state = 6'd0;
      cycle();
      check("pchold_release_addr", mem_addr, 32'd4);

      // Randomized stalls, grants and jumps against the word-stream model
      exp_pc = 32'd4;
      delivered = 0;
      gnt_pct = 70;
      for (int c = 0; c < 800; c++) begin
         stall_state = ($urandom_range(3) == 0) ? {4'd0, 2'($urandom)} : 6'd0;
         jmp_en = ($urandom_range(40) == 0);
         jmp_target = $urandom;
         #1;
         check("rand_if_stall", {31'd0, if_stall}, {31'd0, ~inst_valid & ~jmp_en});
         consumed = inst_valid & ~stall_state[1] & ~stall_state[0] & ~jmp_en;
         if (jmp_en) exp_pc = jmp_target & ~32'd3;
         else if (consumed) exp_pc = exp_pc + 32'd4;
         prev_valid = inst_valid;
         cycle();
         jmp_en = 1'b0;
         if (inst_valid && !prev_valid) begin
            check("rand_inst_pc", inst_pc, exp_pc);
            check("rand_inst", inst, word_at(exp_pc));
            delivered++;
         end
      end
      stall_state = 6'd0;
      check("rand_enough_words", {31'd0, delivered >= 10}, 32'd1);

      // Reset asserted mid-WAIT, stray mem_valid afterwards
      gnt_pct = 100;
      mem_gnt = 1'b1;
      n = 0;
      while (!(mem_req && mem_gnt) && n < 40) begin
         cycle();
         n++;
      end
      check("rstwait_req_seen", {31'd0, mem_req & mem_gnt}, 32'd1);
      cycle();
      check("rstwait_in_wait", {31'd0, mem_req}, 32'd0);
      #2 rst = 1'b0;
      #1;
      check("rstwait_mem_req", {31'd0, mem_req}, 32'd0);
      check("rstwait_mem_addr", mem_addr, 32'd0);
      check("rstwait_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rstwait_inst", inst, 32'd0);
      check("rstwait_inst_pc", inst_pc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_valid = 1'b1;
      mem_rdata = 8'hA5;
      mem_gnt = 1'b1;
      req_log.delete();
      cycle();
      check("rstwait_restart_req", {31'd0, mem_req}, 32'd1);
      check("rstwait_restart_addr", mem_addr, 32'd0);
      wait_valid(40, n);
      check("rstwait_cycles", n, 32'd8);
      check("rstwait_inst_pc_final", inst_pc, 32'd0);
      check("rstwait_inst_final", inst, 32'h00500013);
      check("rstwait_req_count", req_log.size(), 32'd4);
      for (int k = 0; k < 4 && k < req_log.size(); k++)
         check("rstwait_req_addr", req_log[k], k);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
